spi_master_cfg: RTL and testbench

// Parametrised SPI master, successor to the fixed 15-bit, mode-0-only master on the lab board.

---
 rtl/spi_pkg.sv | 25 ++
 rtl/spi_clk_div.sv | 25 ++
 rtl/spi_master_cfg.sv | 138 +++++++++++++
 tb/tb_spi_master_cfg.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and constant helpers for the configurable SPI master.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEAD  = 2'd1,
        XFER  = 2'd2,
        TRAIL = 2'd3
    } state_t;

    // Ceiling log2, usable in constant expressions (clog2(1) = 0).
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < v) r = i + 1;
        return r;
    endfunction

    // Width of a select index for n targets, never below one bit.
    function automatic int sel_w(input int n);
        return (n > 1) ? clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_clk_div.sv
// SCLK half-period divider: ce pulses for one clk every DIV enabled clks.
module spi_clk_div import spi_pkg::*; #(
    parameter int DIV = 100
) (
    input  logic clk,
    input  logic clr,
    input  logic en,
    input  logic sync_clr,
    output logic ce
);

    localparam int TW = clog2(DIV);

    logic [TW-1:0] cnt_q;

    assign ce = en && (cnt_q == TW'(DIV - 1));

    // Tact counter, restarted on a new transfer and after every tick.
    always_ff @(posedge clk or posedge clr) begin
        if (clr)                 cnt_q <= '0;
        else if (sync_clr || ce) cnt_q <= '0;
        else if (en)             cnt_q <= cnt_q + TW'(1);
    end

endmodule

// File: rtl/spi_master_cfg.sv
// Configurable SPI master: DW-bit transfers, four CPOL/CPHA modes,
// MSB/LSB-first, NCS active-low selects, start/busy/done handshake.
module spi_master_cfg import spi_pkg::*; #(
    parameter int DW  = 15,
    parameter int DIV = 100,
    parameter int NCS = 1
) (
    input  logic                    clk,
    input  logic                    clr,
    input  logic                    st,
    input  logic [DW-1:0]           di,
    input  logic [sel_w(NCS)-1:0]   cs_sel,
    input  logic                    cpol,
    input  logic                    cpha,
    input  logic                    lsb_first,
    input  logic                    miso,
    output logic                    sclk,
    output logic                    mosi,
    output logic [NCS-1:0]          cs_n,
    output logic                    busy,
    output logic                    done,
    output logic [DW-1:0]           dout
);

    localparam int EW = clog2(2 * DW);

    state_t          state_q;
    logic            cpol_q, cpha_q, lsb_q;
    logic            sclk_q, mosi_q, busy_q, done_q;
    logic [DW-1:0]   tx_q, rx_q, dout_q;
    logic [EW-1:0]   e_q;
    logic [NCS-1:0]  cs_n_q, cs_dec;
    logic            ce, accept, last_edge, sample_ev, shift_ev;

    function automatic logic first_bit(input logic [DW-1:0] w, input logic lsb);
        return lsb ? w[0] : w[DW-1];
    endfunction

    function automatic logic [DW-1:0] shift_w(input logic [DW-1:0] w, input logic lsb);
        return lsb ? (w >> 1) : (w << 1);
    endfunction

    assign accept    = st && (state_q == IDLE);
    assign last_edge = (e_q == EW'(2 * DW - 1));
    // cpha=0 samples on even edges and shifts on odd ones; cpha=1 is the mirror.
    // The final edge is always odd, so it never shifts in either mode.
    assign sample_ev = ce && (state_q == XFER) && (e_q[0] == cpha_q);
    assign shift_ev  = ce && (state_q == XFER) && (e_q[0] != cpha_q) && !last_edge;

    spi_clk_div #(.DIV(DIV)) u_div (
        .clk      (clk),
        .clr      (clr),
        .en       (busy_q),
        .sync_clr (accept),
        .ce       (ce)
    );

    // One-hot-low select decode; an index at or above NCS matches no line.
    always_comb begin
        cs_dec = '1;
        for (int i = 0; i < NCS; i++)
            cs_dec[i] = (32'(cs_sel) != 32'(i));
    end

    // Transfer FSM with edge counter, tx/rx shifters and registered pins.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= IDLE;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            cs_n_q  <= '1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dout_q  <= '0;
            cpol_q  <= 1'b0;
            cpha_q  <= 1'b0;
            lsb_q   <= 1'b0;
            tx_q    <= '0;
            rx_q    <= '0;
            e_q     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    sclk_q <= cpol_q;
                    mosi_q <= 1'b0;
                    if (st) begin
                        state_q <= LEAD;
                        busy_q  <= 1'b1;
                        cs_n_q  <= cs_dec;
                        cpol_q  <= cpol;
                        cpha_q  <= cpha;
                        lsb_q   <= lsb_first;
                        sclk_q  <= cpol;
                        e_q     <= '0;
                        rx_q    <= '0;
                        // cpha=0 must present the first bit before the first edge
                        if (cpha) begin
                            tx_q <= di;
                        end else begin
                            mosi_q <= first_bit(di, lsb_first);
                            tx_q   <= shift_w(di, lsb_first);
                        end
                    end
                end
                LEAD: if (ce) state_q <= XFER;
                XFER: if (ce) begin
                    sclk_q <= ~sclk_q;
                    if (last_edge) state_q <= TRAIL;
                    else           e_q     <= e_q + EW'(1);
                    if (sample_ev)
                        rx_q <= lsb_q ? {miso, rx_q[DW-1:1]} : {rx_q[DW-2:0], miso};
                    if (shift_ev) begin
                        mosi_q <= first_bit(tx_q, lsb_q);
                        tx_q   <= shift_w(tx_q, lsb_q);
                    end
                end
                TRAIL: if (ce) begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    dout_q  <= rx_q;
                    cs_n_q  <= '1;
                    mosi_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign sclk = sclk_q;
    assign mosi = mosi_q;
    assign cs_n = cs_n_q;
    assign busy = busy_q;
    assign done = done_q;
    assign dout = dout_q;

endmodule

// File: tb/tb_spi_master_cfg.sv
// Directed bench: three instances (DW=8/DIV=2 with 4 and 3 selects, and defaults).
module tb_spi_master_cfg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       clr, cpol, cpha, lsb_first;
    int         n_chk = 0, n_err = 0;

    // instance A: DW=8 DIV=2 NCS=4
    logic       st_a, miso_a, sclk_a, mosi_a, busy_a, done_a;
    logic [7:0] di8, dout_a;
    logic [1:0] sel_a;
    logic [3:0] cs_n_a;
    logic       slave_en, miso_s;
    logic [7:0] slave_word;

    // instance B: DW=8 DIV=2 NCS=3 (a 2-bit select can then address past the last line)
    logic       st_b, miso_b, sclk_b, mosi_b, busy_b, done_b;
    logic [1:0] sel_b;
    logic [2:0] cs_n_b;
    logic [7:0] dout_b;

    // instance C: default parameters
    logic        st_c, miso_c, sclk_c, mosi_c, busy_c, done_c;
    logic [0:0]  sel_c, cs_n_c;
    logic [14:0] di_c, dout_c;

    assign miso_a = slave_en ? miso_s : mosi_a;
    assign miso_c = mosi_c;
    assign miso_b = 1'b0;

    spi_master_cfg #(.DW(8), .DIV(2), .NCS(4)) u_a (
        .clk(clk), .clr(clr), .st(st_a), .di(di8), .cs_sel(sel_a), .cpol(cpol), .cpha(cpha),
        .lsb_first(lsb_first), .miso(miso_a), .sclk(sclk_a), .mosi(mosi_a), .cs_n(cs_n_a),
        .busy(busy_a), .done(done_a), .dout(dout_a));

    spi_master_cfg #(.DW(8), .DIV(2), .NCS(3)) u_b (
        .clk(clk), .clr(clr), .st(st_b), .di(di8), .cs_sel(sel_b), .cpol(cpol), .cpha(cpha),
        .lsb_first(lsb_first), .miso(miso_b), .sclk(sclk_b), .mosi(mosi_b), .cs_n(cs_n_b),
        .busy(busy_b), .done(done_b), .dout(dout_b));

    spi_master_cfg u_c (
        .clk(clk), .clr(clr), .st(st_c), .di(di_c), .cs_sel(sel_c), .cpol(cpol), .cpha(cpha),
        .lsb_first(lsb_first), .miso(miso_c), .sclk(sclk_c), .mosi(mosi_c), .cs_n(cs_n_c),
        .busy(busy_c), .done(done_c), .dout(dout_c));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Run one transfer on A; lat counts clks from the first busy cycle to done.
    // The mode-3 slave drives slave_word LSB-first on falling SCLK; mosi is
    // captured on rising SCLK after the first fall.
    task automatic xfer_a(input logic [7:0] d, input logic [1:0] sel, input logic [3:0] exp_cs,
                          input bit pulse10, output int lat, output int cs_bad,
                          output logic [7:0] cap, output int ncap);
        logic prev;
        int   nfall, sidx;
        prev  = sclk_a;
        st_a  = 1'b1; di8 = d; sel_a = sel;
        tick();
        st_a  = 1'b0;
        lat = 0; cs_bad = 0; cap = '0; ncap = 0; nfall = 0; sidx = 0;
        while (done_a !== 1'b1 && lat < 400) begin
            if (busy_a !== 1'b1 || cs_n_a !== exp_cs) cs_bad++;
            if (sclk_a !== prev) begin
                if (sclk_a == 1'b0) begin
                    nfall++;
                    if (sidx < 8) begin miso_s = slave_word[sidx]; sidx++; end
                end else if (nfall > 0 && ncap < 8) begin
                    cap[ncap] = mosi_a; ncap++;
                end
                prev = sclk_a;
            end
            st_a = (pulse10 && lat == 10);
            if (pulse10 && lat == 10) di8 = 8'hFF;
            tick();
            lat++;
        end
        st_a = 1'b0;
    endtask

    // Count done pulses and busy cycles on A over n clks.
    task automatic quiet_a(input int n, output int nd, output int nb);
        nd = 0; nb = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (done_a === 1'b1) nd++;
            if (busy_a === 1'b1) nb++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, cs_bad, ncap, nd, nb;
        logic [7:0] cap;
        int t[3];
        int nt;
        logic prev;

        clr = 1'b1; cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0;
        st_a = 1'b0; st_b = 1'b0; st_c = 1'b0;
        di8 = '0; di_c = '0; sel_a = '0; sel_b = '0; sel_c = '0;
        slave_en = 1'b0; miso_s = 1'b0; slave_word = '0;
        tick(); tick();

        // reset values
        chk("rst_sclk", sclk_a, 0);
        chk("rst_mosi", mosi_a, 0);
        chk("rst_cs_n", cs_n_a, 4'hF);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_dout", dout_a, 0);
        clr = 1'b0;
        tick();

        // mode 0 loopback, MSB first
        xfer_a(8'hA5, 2'd0, 4'b1110, 1'b0, lat, cs_bad, cap, ncap);
        chk("m0_latency", lat, 36);
        chk("m0_dout", dout_a, 8'hA5);
        chk("m0_busy_at_done", busy_a, 0);
        chk("m0_cs_window", cs_bad, 0);
        chk("m0_cs_release", cs_n_a, 4'hF);
        tick();
        chk("m0_done_pulse", done_a, 0);
        chk("m0_sclk_idle", sclk_a, 0);
        chk("m0_mosi_idle", mosi_a, 0);

        // mode 3, LSB first, slave returns C1
        cpol = 1'b1; cpha = 1'b1; lsb_first = 1'b1;
        slave_en = 1'b1; slave_word = 8'hC1;
        xfer_a(8'h3C, 2'd0, 4'b1110, 1'b0, lat, cs_bad, cap, ncap);
        chk("m3_latency", lat, 36);
        chk("m3_dout", dout_a, 8'hC1);
        chk("m3_mosi_bits", cap, 8'h3C);
        chk("m3_mosi_count", ncap, 8);
        chk("m3_sclk_at_done", sclk_a, 1);
        tick(); tick(); tick();
        chk("m3_sclk_idle", sclk_a, 1);
        slave_en = 1'b0;
        cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0;

        // select 2 of 4
        xfer_a(8'h5E, 2'd2, 4'b1011, 1'b0, lat, cs_bad, cap, ncap);
        chk("cs2_window", cs_bad, 0);
        chk("cs2_dout", dout_a, 8'h5E);
        chk("cs2_latency", lat, 36);

        // start while busy is ignored; di changes after accept must not leak in
        xfer_a(8'h3A, 2'd0, 4'b1110, 1'b1, lat, cs_bad, cap, ncap);
        chk("restart_latency", lat, 36);
        chk("restart_dout", dout_a, 8'h3A);
        quiet_a(60, nd, nb);
        chk("restart_extra_done", nd, 0);
        chk("restart_extra_busy", nb, 0);

        // out-of-range select on the 3-select instance
        sel_b = 2'd3; di8 = 8'h81; st_b = 1'b1;
        tick();
        st_b = 1'b0;
        lat = 0; cs_bad = 0;
        while (done_b !== 1'b1 && lat < 400) begin
            if (busy_b !== 1'b1 || cs_n_b !== 3'b111) cs_bad++;
            tick();
            lat++;
        end
        chk("oor_cs_window", cs_bad, 0);
        chk("oor_done", done_b, 1);
        chk("oor_latency", lat, 36);
        chk("oor_dout", dout_b, 8'h00);

        // clr in the middle of a mode-2 transfer
        cpol = 1'b1; cpha = 1'b0;
        st_a = 1'b1; di8 = 8'h77; sel_a = 2'd1;
        tick();
        st_a = 1'b0;
        repeat (14) tick();
        chk("clr_pre_busy", busy_a, 1);
        chk("clr_pre_sclk", sclk_a, 1);
        clr = 1'b1;
        #1;
        chk("clr_cs_n", cs_n_a, 4'hF);
        chk("clr_sclk", sclk_a, 0);
        chk("clr_busy", busy_a, 0);
        chk("clr_mosi", mosi_a, 0);
        chk("clr_dout", dout_a, 0);
        tick();
        clr = 1'b0;
        cpol = 1'b0;
        quiet_a(60, nd, nb);
        chk("clr_no_done", nd, 0);
        chk("clr_dout_held", dout_a, 0);
        xfer_a(8'h96, 2'd0, 4'b1110, 1'b0, lat, cs_bad, cap, ncap);
        chk("post_clr_latency", lat, 36);
        chk("post_clr_dout", dout_a, 8'h96);
        chk("post_clr_cs", cs_bad, 0);

        // default parameters: DW=15, DIV=100, loopback
        di_c = 15'h5A3C; st_c = 1'b1;
        prev = sclk_c;
        tick();
        st_c = 1'b0;
        lat = 0; nt = 0;
        while (done_c !== 1'b1 && lat < 4000) begin
            if (sclk_c !== prev) begin
                if (nt < 3) t[nt] = lat;
                nt++;
                prev = sclk_c;
            end
            tick();
            lat++;
        end
        chk("def_latency", lat, 3200);
        chk("def_dout", dout_c, 15'h5A3C);
        chk("def_first_edge", t[0], 200);
        chk("def_bit_period", t[2] - t[0], 200);
        chk("def_edge_count", nt, 30);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
